accel_cfg_regs: RTL and testbench
=================================

ACCEL_CFG_REGS -- requirements
Module: accel_cfg_regs

Interface
REQ-001 SHALL have parameter C_S00_AXI_DATA_WIDTH, default 32, AXI-Lite data width.
REQ-002 SHALL have parameter C_S00_AXI_ADDR_WIDTH, default 5, byte address width (8 word registers).
REQ-003 SHALL have parameter VERSION, default 32'h0587_0001, read-only ID value.
REQ-004 CLK  in  1  clock; all logic on rising edge.
REQ-005 RESETN  in  1  reset, synchronous, active-low.
REQ-006 S_AWADDR/S_AWVALID/S_AWREADY  in/in/out  ADDR_W/1/1  write address channel.
REQ-007 S_WDATA/S_WSTRB/S_WVALID/S_WREADY  in/in/in/out  DATA_W/DATA_W/8/1/1  write data channel.
REQ-008 S_BRESP/S_BVALID/S_BREADY  out/out/in  2/1/1  write response channel.
REQ-009 S_ARADDR/S_ARVALID/S_ARREADY  in/in/out  ADDR_W/1/1  read address channel.
REQ-010 S_RDATA/S_RRESP/S_RVALID/S_RREADY  out/out/out/in  DATA_W/2/1/1  read data channel.
REQ-011 params_reg, weight_base_addr, input_base_addr, output_base_addr, mem_ctrl  out  DATA_W each  registered config words to the control unit.
REQ-012 accel_busy  in  1  level from control unit; accel_done  in  1  single-cycle completion pulse.

Function
REQ-013 Word map (addr[4:2]): 0 params_reg RW, 1 weight_base_addr RW, 2 input_base_addr RW, 3 output_base_addr RW, 4 mem_ctrl RW, 5 STATUS, 6 VERSION RO, 7 reserved (reads 0, writes ignored); addr[1:0] ignored.
REQ-014 STATUS: bit0 = accel_busy sampled live, bit1 = done_sticky, others 0.
REQ-015 done_sticky SHALL set on accel_done, clear on write to STATUS with WDATA[1]=1 and WSTRB[0]=1; simultaneous set and clear -> set wins.
REQ-016 params_reg[31] (param_reset) SHALL self-clear one cycle after being written 1 (exactly one-cycle pulse); other bits hold as written.
REQ-017 Writes SHALL honour WSTRB per byte; unstrobed bytes keep old value; writes to RO words SHALL be ignored with BRESP=OKAY.
REQ-018 AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID; AW and W accepted independently in any order or same cycle, each latched on its handshake edge.
REQ-019 At the first edge where aw_held && w_held: register update, BVALID set, both holds cleared; AW+W in same cycle at edge k -> register visible and BVALID high after edge k+1.
REQ-020 BVALID SHALL hold until BREADY handshake; BRESP always 2'b00.
REQ-021 ARREADY = !RVALID; on AR handshake RDATA SHALL be registered from current contents and RVALID set; RDATA/RVALID held stable until RREADY.
REQ-022 Read and write completing at the same edge to the same word: read SHALL return the pre-write value.
REQ-023 RRESP always 2'b00; no error responses generated.
REQ-024 Outputs SHALL be direct register outputs (no combinational path from AXI inputs).

Reset
REQ-025 With RESETN=0 at an edge: all config registers 0, done_sticky 0, holds cleared, AWREADY/WREADY/ARREADY 0 during reset, BVALID/RVALID 0, RDATA 0.
REQ-026 Reset mid-transaction SHALL abandon any held AW/W/pending B or R without issuing a response; first cycle after reset readies return to 1.

Verification
REQ-027 AW(0x04)+W(0xDEADBEEF, strb F) same cycle, BREADY=1 -> weight_base_addr=0xDEADBEEF after 2 edges, one BVALID pulse, BRESP=00.
REQ-028 W(0x11223344, strb 0x5) 3 cycles before AW(0x0C), old value 0 -> output_base_addr=0x00220044; WREADY low after W accepted until B completes.
REQ-029 Write 0xC000_3533 to 0x00 -> params_reg=0xC0003533 for one cycle then 0x40003533.
REQ-030 accel_done pulse then read 0x14 with accel_busy=0 -> RDATA=0x2; write 0x2 to 0x14 in same cycle as another accel_done -> bit1 stays 1.
REQ-031 AR(0x18) with RREADY held low 5 cycles -> RDATA=0x05870001 stable, RVALID high, ARREADY low until RREADY.
REQ-032 AW accepted, RESETN asserted before W -> no BVALID; after reset all outputs 0 and new write completes normally.

Source files
------------

// File: rtl/accel_cfg_regs.sv
// AXI4-Lite configuration/status register block feeding the accelerator control unit.
// Eight word slots: five RW config words, live STATUS, read-only VERSION, one reserved.
module accel_cfg_regs #(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 5,
    parameter logic [C_S00_AXI_DATA_WIDTH-1:0] VERSION = 32'h0587_0001
) (
    input  logic                                CLK,
    input  logic                                RESETN,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     S_AWADDR,
    input  logic                                S_AWVALID,
    output logic                                S_AWREADY,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     S_WDATA,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   S_WSTRB,
    input  logic                                S_WVALID,
    output logic                                S_WREADY,
    output logic [1:0]                          S_BRESP,
    output logic                                S_BVALID,
    input  logic                                S_BREADY,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     S_ARADDR,
    input  logic                                S_ARVALID,
    output logic                                S_ARREADY,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     S_RDATA,
    output logic [1:0]                          S_RRESP,
    output logic                                S_RVALID,
    input  logic                                S_RREADY,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     params_reg,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     weight_base_addr,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     input_base_addr,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     output_base_addr,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     mem_ctrl,
    input  logic                                accel_busy,
    input  logic                                accel_done
);

    localparam int DW = C_S00_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;

    typedef enum logic [2:0] {
        W_PARAMS  = 3'd0,
        W_WEIGHT  = 3'd1,
        W_INPUT   = 3'd2,
        W_OUTPUT  = 3'd3,
        W_MEMCTRL = 3'd4,
        W_STATUS  = 3'd5,
        W_VERSION = 3'd6,
        W_RSVD    = 3'd7
    } word_t;

    logic          ready_q;
    logic          aw_held;
    logic          w_held;
    logic          bvalid_q;
    logic          rvalid_q;
    logic          done_sticky;
    logic [2:0]    aw_word_q;
    logic [DW-1:0] w_data_q;
    logic [SW-1:0] w_strb_q;
    logic [DW-1:0] rdata_q;

    logic          aw_hs;
    logic          w_hs;
    logic          ar_hs;
    logic          wr_fire;
    logic          status_clr;
    logic [DW-1:0] params_base;
    logic [DW-1:0] rd_mux;
    logic          unused_addr_bits;

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                  input logic [DW-1:0] new_v,
                                                  input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_v;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    // ready_q keeps every ready low while in reset and through the reset edge itself
    assign S_AWREADY = ready_q & ~aw_held & ~bvalid_q;
    assign S_WREADY  = ready_q & ~w_held & ~bvalid_q;
    assign S_ARREADY = ready_q & ~rvalid_q;
    assign S_BVALID  = bvalid_q;
    assign S_BRESP   = 2'b00;
    assign S_RVALID  = rvalid_q;
    assign S_RDATA   = rdata_q;
    assign S_RRESP   = 2'b00;

    assign aw_hs      = S_AWVALID & S_AWREADY;
    assign w_hs       = S_WVALID & S_WREADY;
    assign ar_hs      = S_ARVALID & S_ARREADY;
    assign wr_fire    = aw_held & w_held;
    assign status_clr = wr_fire && (word_t'(aw_word_q) == W_STATUS) && w_data_q[1] && w_strb_q[0];

    // param_reset is a pulse, so a later partial write must never resurrect it
    assign params_base      = {1'b0, params_reg[DW-2:0]};
    assign unused_addr_bits = ^{S_AWADDR, S_ARADDR};

    always_comb begin
        rd_mux = '0;
        case (word_t'(S_ARADDR[4:2]))
            W_PARAMS:  rd_mux = params_reg;
            W_WEIGHT:  rd_mux = weight_base_addr;
            W_INPUT:   rd_mux = input_base_addr;
            W_OUTPUT:  rd_mux = output_base_addr;
            W_MEMCTRL: rd_mux = mem_ctrl;
            W_STATUS:  rd_mux[1:0] = {done_sticky, accel_busy};
            W_VERSION: rd_mux = VERSION;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            ready_q          <= 1'b0;
            aw_held          <= 1'b0;
            w_held           <= 1'b0;
            bvalid_q         <= 1'b0;
            rvalid_q         <= 1'b0;
            done_sticky      <= 1'b0;
            aw_word_q        <= '0;
            w_data_q         <= '0;
            w_strb_q         <= '0;
            rdata_q          <= '0;
            params_reg       <= '0;
            weight_base_addr <= '0;
            input_base_addr  <= '0;
            output_base_addr <= '0;
            mem_ctrl         <= '0;
        end else begin
            ready_q             <= 1'b1;
            params_reg[DW-1]    <= 1'b0;

            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_word_q <= S_AWADDR[4:2];
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= S_WDATA;
                w_strb_q <= S_WSTRB;
            end

            if (bvalid_q && S_BREADY) begin
                bvalid_q <= 1'b0;
            end
            // Commit once both halves are held; RO and reserved slots still get OKAY
            if (wr_fire) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                case (word_t'(aw_word_q))
                    W_PARAMS:  params_reg       <= merge_bytes(params_base, w_data_q, w_strb_q);
                    W_WEIGHT:  weight_base_addr <= merge_bytes(weight_base_addr, w_data_q, w_strb_q);
                    W_INPUT:   input_base_addr  <= merge_bytes(input_base_addr, w_data_q, w_strb_q);
                    W_OUTPUT:  output_base_addr <= merge_bytes(output_base_addr, w_data_q, w_strb_q);
                    W_MEMCTRL: mem_ctrl         <= merge_bytes(mem_ctrl, w_data_q, w_strb_q);
                    default:   ;
                endcase
            end

            if (accel_done) begin
                done_sticky <= 1'b1;
            end else if (status_clr) begin
                done_sticky <= 1'b0;
            end

            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (rvalid_q && S_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_accel_cfg_regs.sv
// Directed bench for accel_cfg_regs: a transaction-level register model checked every cycle,
// plus literal expectations for the documented example transactions.
module tb_accel_cfg_regs;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic [4:0]  S_AWADDR = '0;
    logic        S_AWVALID = 1'b0;
    logic        S_AWREADY;
    logic [31:0] S_WDATA = '0;
    logic [3:0]  S_WSTRB = '0;
    logic        S_WVALID = 1'b0;
    logic        S_WREADY;
    logic [1:0]  S_BRESP;
    logic        S_BVALID;
    logic        S_BREADY = 1'b1;
    logic [4:0]  S_ARADDR = '0;
    logic        S_ARVALID = 1'b0;
    logic        S_ARREADY;
    logic [31:0] S_RDATA;
    logic [1:0]  S_RRESP;
    logic        S_RVALID;
    logic        S_RREADY = 1'b0;
    logic [31:0] params_reg;
    logic [31:0] weight_base_addr;
    logic [31:0] input_base_addr;
    logic [31:0] output_base_addr;
    logic [31:0] mem_ctrl;
    logic        accel_busy = 1'b0;
    logic        accel_done = 1'b0;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          compare_en = 1'b0;
    logic [31:0] model_cfg [0:4] = '{default: 32'h0};
    logic        model_sticky = 1'b0;

    accel_cfg_regs dut (
        .CLK              (CLK),
        .RESETN           (RESETN),
        .S_AWADDR         (S_AWADDR),
        .S_AWVALID        (S_AWVALID),
        .S_AWREADY        (S_AWREADY),
        .S_WDATA          (S_WDATA),
        .S_WSTRB          (S_WSTRB),
        .S_WVALID         (S_WVALID),
        .S_WREADY         (S_WREADY),
        .S_BRESP          (S_BRESP),
        .S_BVALID         (S_BVALID),
        .S_BREADY         (S_BREADY),
        .S_ARADDR         (S_ARADDR),
        .S_ARVALID        (S_ARVALID),
        .S_ARREADY        (S_ARREADY),
        .S_RDATA          (S_RDATA),
        .S_RRESP          (S_RRESP),
        .S_RVALID         (S_RVALID),
        .S_RREADY         (S_RREADY),
        .params_reg       (params_reg),
        .weight_base_addr (weight_base_addr),
        .input_base_addr  (input_base_addr),
        .output_base_addr (output_base_addr),
        .mem_ctrl         (mem_ctrl),
        .accel_busy       (accel_busy),
        .accel_done       (accel_done)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic report_timeout(input string name);
        n_checks++;
        n_errors++;
        $display("[TB] FAIL %s: got no handshake, expected one within 40 cycles", name);
    endtask

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] addr);
        int idx;
        idx = int'(addr[4:2]);
        if (idx < 5) return model_cfg[idx];
        if (idx == 5) return {30'h0, model_sticky, accel_busy};
        if (idx == 6) return 32'h0587_0001;
        return 32'h0;
    endfunction

    // Config outputs must track the transaction-level model on every cycle
    always @(negedge CLK) begin
        if (compare_en) begin
            checkOutput("params_reg", params_reg, model_cfg[0]);
            checkOutput("weight_base_addr", weight_base_addr, model_cfg[1]);
            checkOutput("input_base_addr", input_base_addr, model_cfg[2]);
            checkOutput("output_base_addr", output_base_addr, model_cfg[3]);
            checkOutput("mem_ctrl", mem_ctrl, model_cfg[4]);
            checkOutput("bresp_rresp", {28'h0, S_BRESP, S_RRESP}, 32'h0);
        end
    end

    task automatic do_reset(input int cycles);
        RESETN = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge CLK); #1;
            if (i == 0) begin
                for (int r = 0; r < 5; r++) model_cfg[r] = 32'h0;
                model_sticky = 1'b0;
            end
            checkOutput("reset_readies", {29'h0, S_AWREADY, S_WREADY, S_ARREADY}, 32'h0);
            checkOutput("reset_valids", {30'h0, S_BVALID, S_RVALID}, 32'h0);
            checkOutput("reset_rdata", S_RDATA, 32'h0);
        end
        RESETN = 1'b1;
        @(posedge CLK); #1;
        checkOutput("post_reset_readies", {29'h0, S_AWREADY, S_WREADY, S_ARREADY}, 32'h7);
    endtask

    task automatic pulse_done();
        accel_done = 1'b1;
        @(posedge CLK); #1;
        accel_done = 1'b0;
        model_sticky = 1'b1;
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_delay, input int w_delay, input bit done_at_commit,
                             output int edges, output logic [31:0] params_at_commit);
        bit aw_done = 1'b0;
        bit w_done = 1'b0;
        bit committed = 1'b0;
        bit aw_hs, w_hs, commit_next;
        int cyc = 0;
        int idx;
        edges = 0;
        params_at_commit = '0;
        while (!committed && cyc < 40) begin
            S_AWADDR    = addr;
            S_AWVALID   = !aw_done && (cyc >= aw_delay);
            S_WDATA     = data;
            S_WSTRB     = strb;
            S_WVALID    = !w_done && (cyc >= w_delay);
            commit_next = aw_done && w_done;
            accel_done  = done_at_commit && commit_next;
            aw_hs       = S_AWVALID && S_AWREADY;
            w_hs        = S_WVALID && S_WREADY;
            @(posedge CLK); #1;
            cyc++;
            accel_done = 1'b0;
            if (commit_next) begin
                committed = 1'b1;
                edges = cyc;
                params_at_commit = params_reg;
                checkOutput("bvalid_at_commit", {31'h0, S_BVALID}, 32'h1);
                idx = int'(addr[4:2]);
                if (idx < 5) model_cfg[idx] = byte_merge(model_cfg[idx], data, strb);
                if (idx == 5 && strb[0] && data[1]) model_sticky = 1'b0;
                if (done_at_commit) model_sticky = 1'b1;
            end else begin
                if (aw_hs) aw_done = 1'b1;
                if (w_hs) w_done = 1'b1;
                if (w_done && !aw_done) checkOutput("wready_low_while_held", {31'h0, S_WREADY}, 32'h0);
            end
        end
        S_AWVALID = 1'b0;
        S_WVALID  = 1'b0;
        if (!committed) begin
            report_timeout("write_commit");
        end else begin
            // BREADY is high, so the response retires on the next edge and param_reset drops
            @(posedge CLK); #1;
            model_cfg[0][31] = 1'b0;
            checkOutput("bvalid_single_pulse", {31'h0, S_BVALID}, 32'h0);
            checkOutput("aw_w_ready_after_b", {30'h0, S_AWREADY, S_WREADY}, 32'h3);
        end
    endtask

    task automatic axi_read(input logic [4:0] addr, input int ar_delay, input int hold,
                            output logic [31:0] data);
        bit done = 1'b0;
        bit hs;
        int cyc = 0;
        logic [31:0] expv = '0;
        data = '0;
        S_RREADY = 1'b0;
        while (!done && cyc < 40) begin
            S_ARADDR  = addr;
            S_ARVALID = (cyc >= ar_delay);
            hs = S_ARVALID && S_ARREADY;
            if (hs) expv = model_read(addr);
            @(posedge CLK); #1;
            cyc++;
            if (hs) done = 1'b1;
        end
        S_ARVALID = 1'b0;
        if (!done) begin
            report_timeout("read_handshake");
        end else begin
            data = S_RDATA;
            checkOutput("rvalid_set", {31'h0, S_RVALID}, 32'h1);
            checkOutput("rdata_model", S_RDATA, expv);
            for (int i = 0; i < hold; i++) begin
                @(posedge CLK); #1;
                checkOutput("rdata_stable", S_RDATA, expv);
                checkOutput("rvalid_arready_hold", {30'h0, S_RVALID, S_ARREADY}, 32'h2);
            end
            S_RREADY = 1'b1;
            @(posedge CLK); #1;
            S_RREADY = 1'b0;
            checkOutput("rvalid_cleared", {30'h0, S_RVALID, S_ARREADY}, 32'h1);
        end
    endtask

    task automatic applyStimulus();
        int          e, e2;
        logic [31:0] p, p2, rd;

        do_reset(2);
        compare_en = 1'b1;

        // Same-cycle AW+W: visible two edges after presentation
        axi_write(5'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, 1'b0, e, p);
        checkOutput("aw_w_same_cycle_edges", e, 32'd2);
        checkOutput("weight_literal", weight_base_addr, 32'hDEAD_BEEF);

        // W leads AW by three cycles, sparse strobe
        axi_write(5'h0C, 32'h1122_3344, 4'h5, 3, 0, 1'b0, e, p);
        checkOutput("output_strb_literal", output_base_addr, 32'h0022_0044);

        axi_write(5'h04, 32'h0000_0077, 4'h1, 0, 2, 1'b0, e, p);
        checkOutput("weight_byte0_literal", weight_base_addr, 32'hDEAD_BE77);

        axi_write(5'h00, 32'hC000_3533, 4'hF, 0, 0, 1'b0, e, p);
        checkOutput("param_reset_pulse_literal", p, 32'hC000_3533);
        checkOutput("param_after_pulse_literal", params_reg, 32'h4000_3533);

        // Read-only and reserved slots
        axi_write(5'h18, 32'hFFFF_FFFF, 4'hF, 0, 0, 1'b0, e, p);
        axi_read(5'h18, 0, 5, rd);
        checkOutput("version_literal", rd, 32'h0587_0001);
        axi_write(5'h1C, 32'h1234_5678, 4'hF, 1, 0, 1'b0, e, p);
        axi_read(5'h1C, 0, 0, rd);
        checkOutput("reserved_literal", rd, 32'h0);

        // Sticky done flag and its set-wins clear
        accel_busy = 1'b0;
        pulse_done();
        axi_read(5'h14, 0, 0, rd);
        checkOutput("status_done_literal", rd, 32'h2);
        axi_write(5'h14, 32'h2, 4'hF, 0, 0, 1'b1, e, p);
        axi_read(5'h14, 0, 0, rd);
        checkOutput("status_set_wins_literal", rd, 32'h2);
        axi_write(5'h14, 32'h2, 4'hE, 0, 0, 1'b0, e, p);
        axi_read(5'h14, 0, 0, rd);
        checkOutput("status_no_strb0_literal", rd, 32'h2);
        axi_write(5'h14, 32'h2, 4'h1, 0, 0, 1'b0, e, p);
        accel_busy = 1'b1;
        axi_read(5'h14, 0, 1, rd);
        checkOutput("status_cleared_busy_literal", rd, 32'h1);
        accel_busy = 1'b0;

        // Low address bits are ignored; then read races a write to the same word
        axi_write(5'h0B, 32'h1234_5678, 4'hF, 0, 0, 1'b0, e, p);
        checkOutput("input_offset_literal", input_base_addr, 32'h1234_5678);
        fork
            axi_write(5'h08, 32'h5555_AAAA, 4'hF, 0, 0, 1'b0, e, p);
            axi_read(5'h08, 1, 0, rd);
        join
        checkOutput("read_before_write_literal", rd, 32'h1234_5678);
        checkOutput("input_after_race_literal", input_base_addr, 32'h5555_AAAA);

        axi_write(5'h10, 32'h0000_00F1, 4'h1, 2, 1, 1'b0, e, p);
        checkOutput("mem_ctrl_literal", mem_ctrl, 32'h0000_00F1);

        // Reset between AW and W abandons the write
        S_AWADDR  = 5'h10;
        S_AWVALID = 1'b1;
        checkOutput("awready_before_abandon", {31'h0, S_AWREADY}, 32'h1);
        @(posedge CLK); #1;
        S_AWVALID = 1'b0;
        do_reset(2);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            checkOutput("no_bvalid_after_abandon", {31'h0, S_BVALID}, 32'h0);
        end
        checkOutput("weight_reset_literal", weight_base_addr, 32'h0);
        checkOutput("mem_ctrl_reset_literal", mem_ctrl, 32'h0);
        axi_write(5'h10, 32'hA5A5_0F0F, 4'hF, 0, 0, 1'b0, e2, p2);
        checkOutput("mem_ctrl_after_reset_literal", mem_ctrl, 32'hA5A5_0F0F);
        axi_read(5'h14, 0, 0, rd);
        checkOutput("status_after_reset_literal", rd, 32'h0);

        compare_en = 1'b0;
    endtask

    initial begin
        applyStimulus();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
